// File: rtl/mmu_result_drain_if.sv
// Handshake/bus bundle between the result drain and its neighbours:
// array-side accumulator stream, start handshake, status and the tile FIFO pop port.
interface mmu_result_drain_if #(
    parameter int SIZE              = 2,
    parameter int RESULT_FIFO_DEPTH = 3
);
    localparam int CW = $clog2(RESULT_FIFO_DEPTH + 1);

    logic                            start;
    logic                            start_rdy;
    logic [SIZE-1:0][31:0]           acc_in;
    logic                            busy;
    logic                            done;
    logic [SIZE-1:0][SIZE-1:0][31:0] acc_out;
    logic                            acc_out_rdy;
    logic                            acc_out_pop;
    logic [CW-1:0]                   count;

    modport slave (
        input  start, acc_in, acc_out_pop,
        output start_rdy, busy, done, acc_out, acc_out_rdy, count
    );

    modport master (
        output start, acc_in, acc_out_pop,
        input  start_rdy, busy, done, acc_out, acc_out_rdy, count
    );
endinterface

// File: rtl/mmu_result_drain.sv
// De-skews the column-staggered accumulator stream from mmu_array into SIZE x SIZE tiles
// and buffers them in a tile FIFO. Optional MMU_RESULT_RELU_EN clamps negative values to 0.
module mmu_result_drain #(
    parameter int SIZE              = 2,
    parameter int RESULT_FIFO_DEPTH = 3,
    parameter int ARRAY_LATENCY     = 3
) (
    input logic              clk,
    input logic              rst_n,
    mmu_result_drain_if.slave bus
);
    localparam int LAST_K    = 2 * (SIZE - 1);
    localparam int WAIT_LAST = (ARRAY_LATENCY >= 2) ? ARRAY_LATENCY - 2 : 0;
    localparam int CNT_MAX   = (WAIT_LAST > LAST_K) ? WAIT_LAST : LAST_K;
    localparam int CNT_W     = (CNT_MAX >= 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int PW        = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam int CW        = $clog2(RESULT_FIFO_DEPTH + 1);

    typedef logic [SIZE-1:0][SIZE-1:0][31:0] tile_t;
    typedef enum logic [1:0] {IDLE, WAIT, COLLECT, PUSH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    tile_t            asm_tile;
    logic             busy_q;
    logic             done_q;

    tile_t            fifo_mem [RESULT_FIFO_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    logic             start_rdy;
    logic             push;
    logic             pop;

    function automatic logic [31:0] clamp(input logic [31:0] v);
`ifdef MMU_RESULT_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RESULT_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_rdy = (state == IDLE) && (count_q < CW'(RESULT_FIFO_DEPTH));
    assign push      = (state == PUSH);
    assign pop       = bus.acc_out_pop && (count_q != '0);

    // In COLLECT, cnt is the diagonal index k: element [i][j] arrives when k == i + j.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            asm_tile <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && start_rdy) begin
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= (ARRAY_LATENCY == 1) ? COLLECT : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(WAIT_LAST)) begin
                        cnt   <= '0;
                        state <= COLLECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < SIZE; i++) begin
                        for (int j = 0; j < SIZE; j++) begin
                            if (cnt == CNT_W'(i + j)) begin
                                asm_tile[i][j] <= clamp(bus.acc_in[j]);
                            end
                        end
                    end
                    if (cnt == CNT_W'(LAST_K)) begin
                        state <= PUSH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PUSH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A push never checks for space: the slot was reserved when start was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int d = 0; d < RESULT_FIFO_DEPTH; d++) begin
                fifo_mem[d] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[tail] <= asm_tile;
                tail           <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.start_rdy   = start_rdy;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.acc_out     = fifo_mem[head];
    assign bus.acc_out_rdy = (count_q != '0);
    assign bus.count       = count_q;
endmodule
